// File: rtl/request_encoder.sv
`default_nettype none
// ============================================================================
// Module  : request_encoder
// Brief   : 16-line sticky request queue that emits one 4-bit code per
//           VALID/READY handshake, fixed-priority or round-robin selection.
// Revision: 1.0 - initial release
// ============================================================================
module request_encoder #(
  parameter int PRIORITY_MODE = 0
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [15:0] req_i,
  input  logic        ready_i,
  output logic        valid_o,
  output logic        a0_o,
  output logic        a1_o,
  output logic        a2_o,
  output logic        a3_o,
  output logic [15:0] pending_o,
  output logic        overrun_o
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t      state_q;
  logic        valid_q;
  logic [3:0]  code_q;
  logic [3:0]  ptr_q;
  logic [15:0] pending_q;
  logic        overrun_q;

  logic        accept;
  logic [15:0] clr_mask;
  logic [15:0] rem;
  logic [15:0] pending_d;
  logic        overrun_d;
  logic [3:0]  ptr_d;

  // Mode 1 scans upward from ptr with 4-bit wrap; mode 0 always scans from 0.
  function automatic logic [3:0] select_f(input logic [15:0] vec, input logic [3:0] ptr);
    logic [3:0] idx;
    logic       found;
    select_f = 4'd0;
    found    = 1'b0;
    for (int k = 0; k < 16; k++) begin
      idx = (PRIORITY_MODE != 0) ? (ptr + 4'(k)) : 4'(k);
      if (!found && vec[idx]) begin
        select_f = idx;
        found    = 1'b1;
      end
    end
  endfunction

  always_comb begin
    accept    = valid_q & ready_i;
    clr_mask  = accept ? (16'd1 << code_q) : 16'd0;
    rem       = pending_q & ~clr_mask;
    pending_d = rem | req_i;
    overrun_d = |(req_i & rem);
    ptr_d     = code_q + 4'd1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      valid_q   <= 1'b0;
      code_q    <= 4'd0;
      ptr_q     <= 4'd0;
      pending_q <= 16'd0;
      overrun_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      case (state_q)
        IDLE: begin
          if (|pending_q) begin
            code_q  <= select_f(pending_q, ptr_q);
            valid_q <= 1'b1;
            state_q <= SEND;
          end
        end
        SEND: begin
          // Code stays frozen until accepted; new arrivals only join the queue.
          if (accept) begin
            ptr_q <= ptr_d;
            if (|rem) begin
              code_q <= select_f(rem, ptr_d);
            end else begin
              valid_q <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign valid_o                  = valid_q;
  assign {a0_o, a1_o, a2_o, a3_o} = code_q;
  assign pending_o                = pending_q;
  assign overrun_o                = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_request_encoder.sv
`default_nettype none
// ============================================================================
// Module  : tb_request_encoder
// Brief   : Scoreboard bench; instance 0 runs fixed priority, instance 1 round-robin.
// Revision: 1.0 - initial release
// ============================================================================
module tb_request_encoder;

  logic        clk;
  logic        rst_n;
  logic [15:0] req;
  logic        ready;

  logic        dvalid [2];
  logic [3:0]  dcode  [2];
  logic [15:0] dpend  [2];
  logic        dovr   [2];

  int checks   = 0;
  int failures = 0;
  bit started  = 1'b0;

  request_encoder #(.PRIORITY_MODE(0)) u_fixed (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req), .ready_i(ready),
    .valid_o(dvalid[0]), .a0_o(dcode[0][3]), .a1_o(dcode[0][2]),
    .a2_o(dcode[0][1]), .a3_o(dcode[0][0]),
    .pending_o(dpend[0]), .overrun_o(dovr[0])
  );

  request_encoder #(.PRIORITY_MODE(1)) u_rr (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req), .ready_i(ready),
    .valid_o(dvalid[1]), .a0_o(dcode[1][3]), .a1_o(dcode[1][2]),
    .a2_o(dcode[1][1]), .a3_o(dcode[1][0]),
    .pending_o(dpend[1]), .overrun_o(dovr[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a set of outstanding events plus the code on offer.
  bit [15:0] m_pend  [2];
  bit        m_valid [2];
  bit        m_ovr   [2];
  int        m_code  [2];
  int        m_ptr   [2];
  int        expq    [2][$];

  function automatic int scan(input bit [15:0] v, input int p, input int rr);
    for (int k = 0; k < 16; k++) begin
      int idx;
      idx = rr ? (p + k) % 16 : k;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      bit        acc;
      bit [15:0] kept;
      int        s;
      if (!rst_n) begin
        m_pend[u]  = '0;
        m_valid[u] = 1'b0;
        m_ovr[u]   = 1'b0;
        m_code[u]  = 0;
        m_ptr[u]   = 0;
        expq[u].delete();
        started    = 1'b1;
      end else begin
        acc  = m_valid[u] && ready;
        kept = m_pend[u];
        if (acc) kept[m_code[u]] = 1'b0;
        m_ovr[u] = |(req & kept);
        if (!m_valid[u]) begin
          s = scan(m_pend[u], m_ptr[u], u);
          if (s >= 0) begin
            m_code[u]  = s;
            m_valid[u] = 1'b1;
            expq[u].push_back(s);
          end
        end else if (acc) begin
          m_ptr[u] = (m_code[u] + 1) % 16;
          s = scan(kept, m_ptr[u], u);
          if (s >= 0) begin
            m_code[u] = s;
            expq[u].push_back(s);
          end else begin
            m_valid[u] = 1'b0;
          end
        end
        m_pend[u] = kept | req;
      end
    end
  end

  task automatic chk(input string name, input int u, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s inst=%0d t=%0t got=%0h exp=%0h", name, u, $time, got, exp);
    end
  endtask

  // Monitor: per-cycle status plus an in-order pop on every accepted code.
  always @(negedge clk) begin
    if (started) begin
      for (int u = 0; u < 2; u++) begin
        chk("valid",   u, int'(dvalid[u]), int'(m_valid[u]));
        chk("code",    u, int'(dcode[u]),  m_code[u]);
        chk("pending", u, int'(dpend[u]),  int'(m_pend[u]));
        chk("overrun", u, int'(dovr[u]),   int'(m_ovr[u]));
        if (rst_n && dvalid[u] && ready) begin
          if (expq[u].size() == 0) begin
            chk("accept_underflow", u, 1, 0);
          end else begin
            chk("accept_code", u, int'(dcode[u]), expq[u].pop_front());
          end
        end
      end
    end
  end

  task automatic drive(input logic [15:0] r, input logic rdy, input int n);
    for (int i = 0; i < n; i++) begin
      req   = r;
      ready = rdy;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 16'hFFFF;
    ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(16'h0000, 1'b1, 3);

    // single request, two-cycle latency
    drive(16'h0020, 1'b1, 1);
    drive(16'h0000, 1'b1, 6);
    // four requests drained back to back
    drive(16'h8421, 1'b1, 1);
    drive(16'h0000, 1'b1, 8);
    // backpressure with a late arrival
    drive(16'h0008, 1'b0, 1);
    drive(16'h0000, 1'b0, 2);
    drive(16'h0002, 1'b0, 1);
    drive(16'h0000, 1'b0, 2);
    drive(16'h0000, 1'b1, 6);
    // two requests held high: round-robin alternates and wraps
    drive(16'h8001, 1'b1, 12);
    drive(16'h0000, 1'b1, 6);
    // repeated request 7 merges, re-arms in its own accept cycle
    drive(16'h0080, 1'b0, 1);
    drive(16'h0000, 1'b0, 2);
    drive(16'h0080, 1'b0, 1);
    drive(16'h0000, 1'b0, 1);
    drive(16'h0080, 1'b1, 1);
    drive(16'h0000, 1'b1, 6);
    // reset in the middle of a handshake
    drive(16'h0F0F, 1'b0, 4);
    rst_n = 1'b0;
    drive(16'h1234, 1'b1, 1);
    rst_n = 1'b1;
    drive(16'h0000, 1'b1, 4);

    for (int i = 0; i < 3000; i++) begin
      logic [15:0] r;
      r = 16'($urandom) & 16'($urandom) & 16'($urandom);
      if ($urandom_range(0, 3) == 0) r = 16'h0000;
      rst_n = ($urandom_range(0, 399) != 0);
      drive(r, ($urandom_range(0, 9) < 7), 1);
    end
    rst_n = 1'b1;
    drive(16'h0000, 1'b1, 40);

    for (int u = 0; u < 2; u++) begin
      chk("queue_drained", u, expq[u].size(), 0);
      chk("idle_at_end",   u, int'(dvalid[u]), 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
